dmem_mmio: RTL and testbench

//   Responder end of the core's data-memory port: services o_mem_addr/o_mem_data/o_mem_we/o_mem_mask
//   and returns i_mem_data with fixed 1-cycle read latency (core holds load address for 2 cycles).

---
 rtl/dmem_mmio_pkg.sv | 42 ++++
 rtl/bram_be.sv | 34 +++
 rtl/dmem_mmio.sv | 147 ++++++++++++++
 tb/tb_dmem_mmio.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: shared memory-map constants, read-select type and byte-mask
// helper for the data-memory responder.
//   MMIO_SEL_BIT    word-address bit that selects the MMIO region
//   MMIO_OFF_WIDTH  number of word-address bits decoding the register offset
//   MMIO_*          register word offsets inside the MMIO region
//   TCMP_RESET      reset value of the compare timer
package dmem_mmio_pkg;

    localparam int          MMIO_SEL_BIT   = 29;
    localparam int          MMIO_OFF_WIDTH = 3;

    localparam logic [2:0]  MMIO_GPIO   = 3'd0;
    localparam logic [2:0]  MMIO_CYC_LO = 3'd1;
    localparam logic [2:0]  MMIO_CYC_HI = 3'd2;
    localparam logic [2:0]  MMIO_TCMP   = 3'd3;
    localparam logic [2:0]  MMIO_STATUS = 3'd4;
    localparam logic [2:0]  MMIO_TOHOST = 3'd5;

    localparam logic [31:0] TCMP_RESET  = 32'hFFFF_FFFF;

    // Source that drives o_data during the cycle after an address is sampled.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_MMIO = 2'd2
    } rd_sel_e;

    // Replace only the bytes of old_val whose mask bit is set.
    function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_be.sv
// bram_be: 32-bit x 2^AW single-port RAM with four byte enables and a
// registered, read-first output.
//   clk    clock
//   we     write strobe
//   be     byte enables, bit n covers wdata[8n+7:8n]
//   addr   word address
//   wdata  write data
//   rdata  contents of addr as seen before any write at the same edge
module bram_be #(
    parameter int    AW        = 10,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // The read uses the pre-edge array contents, which gives read-first
    // behaviour when the same word is written in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: responder for the core's data-memory port. Word addresses with
// bit 29 clear go to byte-writable RAM, with bit 29 set to the MMIO registers
// (GPIO, 64-bit cycle counter with atomic HI snapshot, compare timer, tohost).
// Reads return one cycle after the address is sampled.
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_addr       word address
//   i_data       lane-aligned store data
//   i_we         store strobe
//   i_mask       byte enables
//   o_data       read data for the previously sampled address
//   o_gpio       GPIO_OUT register
//   o_timer_irq  STATUS[0] (compare match, sticky)
//   o_halt       sticky, set by any TOHOST write
//   o_tohost     TOHOST register
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int    RAM_AW    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        i_we,
    input  logic [3:0]  i_mask,
    output logic [31:0] o_data,
    output logic [31:0] o_gpio,
    output logic        o_timer_irq,
    output logic        o_halt,
    output logic [31:0] o_tohost
);

    logic                      is_mmio;
    logic [MMIO_OFF_WIDTH-1:0] off;
    logic                      ram_we;
    logic                      mmio_wr;
    logic                      lo_read;
    logic                      w1c;
    logic                      match;
    logic [31:0]               ram_q;
    logic                      unused_addr_bits;

    logic [31:0] gpio_reg;
    logic [63:0] cycle_reg;
    logic [31:0] tcmp_reg;
    logic        status_reg;
    logic [31:0] tohost_reg;
    logic        halt_reg;
    logic [31:0] hi_snap_reg;
    logic [31:0] mmio_rd_reg;
    logic [31:0] mmio_rd_next;
    rd_sel_e     sel_reg;

    assign is_mmio = i_addr[MMIO_SEL_BIT];
    assign off     = i_addr[MMIO_OFF_WIDTH-1:0];
    assign mmio_wr = i_we & is_mmio;
    assign lo_read = is_mmio & ~i_we & (off == MMIO_CYC_LO);
    assign w1c     = mmio_wr & (off == MMIO_STATUS) & i_mask[0] & i_data[0];
    assign match   = (cycle_reg[31:0] == tcmp_reg);

    // Qualifying with rst_n keeps an edge that arrives while reset is held
    // from committing a store into RAM.
    assign ram_we  = i_we & ~is_mmio & rst_n;

    // Upper RAM-region bits alias; they are intentionally not decoded.
    assign unused_addr_bits = ^i_addr[28:RAM_AW];

    bram_be #(
        .AW        (RAM_AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (i_mask),
        .addr  (i_addr[RAM_AW-1:0]),
        .wdata (i_data),
        .rdata (ram_q)
    );

    always_comb begin
        mmio_rd_next = '0;
        case (off)
            MMIO_GPIO:   mmio_rd_next = gpio_reg;
            MMIO_CYC_LO: mmio_rd_next = cycle_reg[31:0];
            MMIO_CYC_HI: mmio_rd_next = hi_snap_reg;
            MMIO_TCMP:   mmio_rd_next = tcmp_reg;
            MMIO_STATUS: mmio_rd_next = {31'd0, status_reg};
            MMIO_TOHOST: mmio_rd_next = tohost_reg;
            default:     mmio_rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_reg    <= '0;
            cycle_reg   <= '0;
            tcmp_reg    <= TCMP_RESET;
            status_reg  <= 1'b0;
            tohost_reg  <= '0;
            halt_reg    <= 1'b0;
            hi_snap_reg <= '0;
            mmio_rd_reg <= '0;
            sel_reg     <= SEL_ZERO;
        end else begin
            cycle_reg   <= cycle_reg + 64'd1;
            mmio_rd_reg <= mmio_rd_next;
            sel_reg     <= is_mmio ? SEL_MMIO : SEL_RAM;

            // Latching HI on a LO read makes a LO-then-HI sequence atomic.
            if (lo_read) begin
                hi_snap_reg <= cycle_reg[63:32];
            end

            // A match in the same cycle as a W1C wins.
            status_reg <= match | (status_reg & ~w1c);

            if (mmio_wr) begin
                case (off)
                    MMIO_GPIO:   gpio_reg   <= apply_mask(gpio_reg, i_data, i_mask);
                    MMIO_TCMP:   tcmp_reg   <= apply_mask(tcmp_reg, i_data, i_mask);
                    MMIO_TOHOST: begin
                        tohost_reg <= apply_mask(tohost_reg, i_data, i_mask);
                        halt_reg   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_data = '0;
        case (sel_reg)
            SEL_RAM:  o_data = ram_q;
            SEL_MMIO: o_data = mmio_rd_reg;
            default:  o_data = '0;
        endcase
    end

    assign o_gpio      = gpio_reg;
    assign o_timer_irq = status_reg;
    assign o_halt      = halt_reg;
    assign o_tohost    = tohost_reg;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed bench for dmem_mmio. Read transactions push their
// expected data into a scoreboard queue; a monitor pops and compares o_data
// one cycle after each issued address. Status outputs are checked directly.
module tb_dmem_mmio;

    localparam logic [29:0] A_GPIO   = 30'h2000_0000;
    localparam logic [29:0] A_CYC_LO = 30'h2000_0001;
    localparam logic [29:0] A_CYC_HI = 30'h2000_0002;
    localparam logic [29:0] A_TCMP   = 30'h2000_0003;
    localparam logic [29:0] A_STATUS = 30'h2000_0004;
    localparam logic [29:0] A_TOHOST = 30'h2000_0005;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] i_addr = '0;
    logic [31:0] i_data = '0;
    logic        i_we = 1'b0;
    logic [3:0]  i_mask = '0;
    logic [31:0] o_data;
    logic [31:0] o_gpio;
    logic        o_timer_irq;
    logic        o_halt;
    logic [31:0] o_tohost;

    int errors = 0;
    int checks = 0;

    logic        issued = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [63:0] tb_cyc;

    dmem_mmio #(.RAM_AW(10), .INIT_FILE("")) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_we        (i_we),
        .i_mask      (i_mask),
        .o_data      (o_data),
        .o_gpio      (o_gpio),
        .o_timer_irq (o_timer_irq),
        .o_halt      (o_halt),
        .o_tohost    (o_tohost)
    );

    always #5 clk = ~clk;

    // Reference count of cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 64'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard monitor: a read address sampled at the last posedge yields data now.
    always @(posedge clk) pend <= issued;

    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got %h with no expected entry", o_data);
            end else begin
                chk(name_q.pop_front(), o_data, exp_q.pop_front());
            end
        end
    end

    // All drive tasks are entered at a negedge and return at the next negedge.
    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
        i_addr = a; i_data = d; i_mask = m; i_we = 1'b1; issued = 1'b0;
        @(negedge clk);
        i_we = 1'b0; i_mask = '0;
    endtask

    task automatic rd(input logic [29:0] a, input logic [31:0] exp, input string name);
        i_addr = a; i_we = 1'b0; i_mask = '0; issued = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        issued = 1'b0;
    endtask

    task automatic wrrd(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                        input logic [31:0] exp, input string name);
        i_addr = a; i_data = d; i_mask = m; i_we = 1'b1; issued = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        i_we = 1'b0; i_mask = '0; issued = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_o_data", o_data, 32'h0);
        chk("rst_gpio", o_gpio, 32'h0);
        chk("rst_irq", {31'd0, o_timer_irq}, 32'h0);
        chk("rst_halt", {31'd0, o_halt}, 32'h0);
        chk("rst_tohost", o_tohost, 32'h0);
        rst_n = 1'b1;
        rd(A_CYC_LO, 32'h0, "rst_cycle_lo");
        rd(A_TCMP, 32'hFFFF_FFFF, "rst_tcmp");
        rd(A_CYC_HI, 32'h0, "rst_cycle_hi");

        // Compare timer: match at cycle 100, W1C in the same cycle loses
        wr(A_TCMP, 32'd100, 4'b1111);
        rd(A_TCMP, 32'd100, "tcmp_write");
        for (int k = 0; k < 300 && tb_cyc != 64'd100; k++) @(negedge clk);
        chk("wait_cycle_100", tb_cyc[31:0], 32'd100);
        chk("irq_before_match", {31'd0, o_timer_irq}, 32'h0);
        wr(A_STATUS, 32'h1, 4'b0001);
        chk("irq_set_wins", {31'd0, o_timer_irq}, 32'h1);
        wr(A_STATUS, 32'h1, 4'b0010);
        chk("irq_w1c_no_mask0", {31'd0, o_timer_irq}, 32'h1);
        rd(A_STATUS, 32'h1, "status_read_set");
        wr(A_STATUS, 32'h1, 4'b0001);
        chk("irq_w1c_clear", {31'd0, o_timer_irq}, 32'h0);
        rd(A_STATUS, 32'h0, "status_read_clr");

        // RAM byte masks
        wr(30'd5, 32'hDEAD_BEEF, 4'b1111);
        wr(30'd5, 32'h0000_5500, 4'b0010);
        rd(30'd5, 32'hDEAD_55EF, "ram_masked");
        wr(30'd5, 32'hFFFF_FFFF, 4'b0000);
        rd(30'd5, 32'hDEAD_55EF, "ram_mask0_noop");
        rd(30'h0000_0405, 32'hDEAD_55EF, "ram_alias");

        // Read-first on same-cycle write and read
        wr(30'd7, 32'h0, 4'b1111);
        wrrd(30'd7, 32'h1111_1111, 4'b1111, 32'h0, "ram_read_first");
        rd(30'd7, 32'h1111_1111, "ram_after_write");

        // GPIO, unused offsets, aliasing, ignored writes
        wr(A_GPIO, 32'hA5A5_1234, 4'b1111);
        chk("gpio_full", o_gpio, 32'hA5A5_1234);
        wr(A_GPIO, 32'h00FF_0000, 4'b0100);
        chk("gpio_masked", o_gpio, 32'hA5FF_1234);
        rd(30'h2000_0006, 32'h0, "mmio_off6");
        rd(30'h2000_0007, 32'h0, "mmio_off7");
        rd(30'h2000_0010, 32'hA5FF_1234, "gpio_alias");
        wr(30'h2000_0001, 32'hFFFF_FFFF, 4'b1111);
        wr(30'h2000_0002, 32'hFFFF_FFFF, 4'b1111);
        wr(30'h2000_0006, 32'hFFFF_FFFF, 4'b1111);
        chk("gpio_after_ign_wr", o_gpio, 32'hA5FF_1234);
        rd(30'h2000_0006, 32'h0, "off6_after_wr");
        rd(A_CYC_HI, 32'h0, "hi_after_ign_wr");
        rd(A_TCMP, 32'd100, "tcmp_after_ign_wr");

        // Counter near the 32-bit boundary: HI snapshot stays atomic
        force dut.cycle_reg = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.cycle_reg;
        rd(A_CYC_LO, 32'hFFFF_FFFE, "lo_near_wrap");
        rd(A_CYC_HI, 32'h0, "hi_atomic");
        rd(A_CYC_LO, 32'h0, "lo_after_wrap");
        rd(A_CYC_HI, 32'h1, "hi_after_wrap");
        force dut.cycle_reg = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle_reg;
        rd(A_CYC_LO, 32'hFFFF_FFFF, "lo_max");
        rd(A_CYC_LO, 32'h0, "lo_wrap64");
        rd(A_CYC_HI, 32'h0, "hi_wrap64");

        // TOHOST / halt, then asynchronous reset mid-run
        wr(A_TOHOST, 32'h0000_0001, 4'b0000);
        chk("halt_mask0", {31'd0, o_halt}, 32'h1);
        chk("tohost_mask0", o_tohost, 32'h0);
        wr(A_TOHOST, 32'h0000_0001, 4'b0001);
        chk("halt_set", {31'd0, o_halt}, 32'h1);
        chk("tohost_val", o_tohost, 32'h1);
        rd(30'd5, 32'hDEAD_55EF, "ram_before_reset");
        i_addr = 30'd5; i_data = 32'h0; i_mask = 4'b1111; i_we = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_o_data", o_data, 32'h0);
        chk("async_gpio", o_gpio, 32'h0);
        chk("async_halt", {31'd0, o_halt}, 32'h0);
        chk("async_tohost", o_tohost, 32'h0);
        chk("async_irq", {31'd0, o_timer_irq}, 32'h0);
        @(negedge clk);
        i_we = 1'b0; i_mask = '0;
        rst_n = 1'b1;
        rd(30'd5, 32'hDEAD_55EF, "ram_retained");
        rd(A_CYC_LO, 32'h1, "cycle_after_reset");

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
